// File: rtl/bthreadgroup_ctrl_if.sv
// ---------------------------------------------------------------------------
// bthreadgroup_ctrl_if
//   Groups the job, operand-stream, threadgroup and result signals of the
//   bThreadgroup sequencing controller.
//   Job:         start, k_steps, busy
//   Operand:     op_valid, op_ready, tg_issue
//   Threadgroup: tg_psum0..3 (to partial_sum), tg_result0..3 (from result)
//   Result:      out_valid, out_ready, out_data0..3
//   Modports:    slave  - the controller
//                master - the environment driving jobs and consuming results
// ---------------------------------------------------------------------------
interface bthreadgroup_ctrl_if #(
  parameter int KW = 8
);
  logic                 start;
  logic [KW-1:0]        k_steps;
  logic                 busy;

  logic                 op_valid;
  logic                 op_ready;
  logic                 tg_issue;

  logic signed [15:0]   tg_psum0, tg_psum1, tg_psum2, tg_psum3;
  logic signed [15:0]   tg_result0, tg_result1, tg_result2, tg_result3;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [15:0]   out_data0, out_data1, out_data2, out_data3;

  modport slave (
    input  start, k_steps, op_valid, out_ready,
           tg_result0, tg_result1, tg_result2, tg_result3,
    output busy, op_ready, tg_issue, out_valid,
           tg_psum0, tg_psum1, tg_psum2, tg_psum3,
           out_data0, out_data1, out_data2, out_data3
  );

  modport master (
    output start, k_steps, op_valid, out_ready,
           tg_result0, tg_result1, tg_result2, tg_result3,
    input  busy, op_ready, tg_issue, out_valid,
           tg_psum0, tg_psum1, tg_psum2, tg_psum3,
           out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/bthreadgroup_ctrl.sv
// ---------------------------------------------------------------------------
// bthreadgroup_ctrl
//   Sequences one K-chunked dot-product job through a bThreadgroup of four
//   bFEDP lanes. Each operand beat is handshaked from upstream, the previous
//   lane results are fed back as partial sums, and after the last beat the
//   four 16-bit results are offered on a valid/ready port.
//
// Parameters:
//   FEDP_LAT - cycles from beat issue until tg_result0..3 are valid (>=1)
//   KW       - width of the beat-count field
//
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset
//   bus (slave)        - job / operand / threadgroup / result signals
//   perf_busy_cycles   - cycles spent outside IDLE (BTG_CTRL_PERF_EN only)
//   perf_stall_cycles  - ISSUE cycles without op_valid plus OUT cycles
//                        without out_ready (BTG_CTRL_PERF_EN only)
//
// Optional feature macro: BTG_CTRL_PERF_EN (saturating performance counters).
// ---------------------------------------------------------------------------
module bthreadgroup_ctrl #(
  parameter int FEDP_LAT = 2,
  parameter int KW       = 8
) (
  input  logic                clk,
  input  logic                rstn,
  bthreadgroup_ctrl_if.slave  bus
`ifdef BTG_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_busy_cycles,
  output logic [31:0]         perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_e;

  localparam int            WW        = (FEDP_LAT > 1) ? $clog2(FEDP_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LOAD = WW'(FEDP_LAT - 1);

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KW-1:0]        beat_q, beat_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic                 first_q, first_d;
  logic [3:0][15:0]     acc_q, acc_d;

  logic [3:0][15:0]     tg_res;
  logic                 issue_hs;
  logic                 wait_done;

  assign tg_res    = {bus.tg_result3, bus.tg_result2, bus.tg_result1, bus.tg_result0};
  assign issue_hs  = (state_q == S_ISSUE) && bus.op_valid;
  assign wait_done = (state_q == S_WAIT) && (wait_q == '0);

  // -------------------------------------------------------------------------
  // State register and datapath flops
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      first_q <= 1'b1;
      // NOTE: the four accumulators are plain flops, not a RAM, so they are
      // reset here; this is what returns tg_psum/out_data to 0 on abort.
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      first_q <= first_d;
      acc_q   <= acc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start)     state_d = (bus.k_steps != '0) ? S_ISSUE : S_OUT;
      S_ISSUE: if (bus.op_valid)  state_d = S_WAIT;
      S_WAIT:  if (wait_q == '0)  state_d = (beat_q == k_q) ? S_OUT : S_ISSUE;
      S_OUT:   if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values: job capture, beat/wait counting, result latch
  // -------------------------------------------------------------------------
  always_comb begin
    k_d     = k_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    first_d = first_q;
    acc_d   = acc_q;

    if ((state_q == S_IDLE) && bus.start) begin
      k_d     = bus.k_steps;
      beat_d  = '0;
      first_d = 1'b1;
      acc_d   = '0;
    end

    if (issue_hs) begin
      beat_d  = beat_q + 1'b1;
      wait_d  = WAIT_LOAD;
      first_d = 1'b0;
    end

    // The wait counter expires in the cycle the threadgroup result becomes
    // valid (FEDP_LAT cycles after the issue), so the latch happens then.
    if (state_q == S_WAIT) begin
      if (wait_done) acc_d  = tg_res;
      else           wait_d = wait_q - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.op_ready  = (state_q == S_ISSUE);
    bus.tg_issue  = issue_hs;
    bus.out_valid = (state_q == S_OUT);

    // The first beat of a job must start from a zero partial sum; later
    // beats continue from the latched lane results.
    bus.tg_psum0  = first_q ? 16'sd0 : acc_q[0];
    bus.tg_psum1  = first_q ? 16'sd0 : acc_q[1];
    bus.tg_psum2  = first_q ? 16'sd0 : acc_q[2];
    bus.tg_psum3  = first_q ? 16'sd0 : acc_q[3];

    bus.out_data0 = acc_q[0];
    bus.out_data1 = acc_q[1];
    bus.out_data2 = acc_q[2];
    bus.out_data3 = acc_q[3];
  end

`ifdef BTG_CTRL_PERF_EN
  // -------------------------------------------------------------------------
  // Saturating performance counters, cleared only by reset
  // -------------------------------------------------------------------------
  logic [31:0] busy_cnt_q, busy_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_evt;

  assign stall_evt = ((state_q == S_ISSUE) && !bus.op_valid) ||
                     ((state_q == S_OUT)   && !bus.out_ready);

  always_comb begin
    busy_cnt_d  = busy_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q != S_IDLE) && (busy_cnt_q != '1)) busy_cnt_d  = busy_cnt_q + 1'b1;
    if (stall_evt && (stall_cnt_q != '1))          stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_busy_cycles  = busy_cnt_q;
  assign perf_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bthreadgroup_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bthreadgroup_ctrl
//   Directed bench for bthreadgroup_ctrl with a behavioural threadgroup model
//   (FEDP_LAT-deep pipeline). Mode 0 returns fixed lane values 5/-3/7/0,
//   mode 1 returns partial_sum+10 on every lane. Off-cycle model outputs are
//   a junk value so a mistimed result latch shows up in the data.
// ---------------------------------------------------------------------------
module tb_bthreadgroup_ctrl;

  localparam int FEDP_LAT = 2;
  localparam int KW       = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bthreadgroup_ctrl_if #(.KW(KW)) bus ();

`ifdef BTG_CTRL_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_stall_cycles;
`endif

  bthreadgroup_ctrl #(
    .FEDP_LAT (FEDP_LAT),
    .KW       (KW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef BTG_CTRL_PERF_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // ---------------- threadgroup model ----------------
  int mode = 0;
  logic signed [15:0] pipe [FEDP_LAT][4];
  logic signed [15:0] psum_v [4];

  assign psum_v[0] = bus.tg_psum0;
  assign psum_v[1] = bus.tg_psum1;
  assign psum_v[2] = bus.tg_psum2;
  assign psum_v[3] = bus.tg_psum3;

  function automatic logic signed [15:0] tg_fn(input int lane, input logic signed [15:0] p);
    if (mode == 0) begin
      case (lane)
        0:       return 16'sd5;
        1:       return -16'sd3;
        2:       return 16'sd7;
        default: return 16'sd0;
      endcase
    end
    return p + 16'sd10;
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      pipe[0][l] <= bus.tg_issue ? tg_fn(l, psum_v[l]) : 16'sh5A5A;
      for (int s = 1; s < FEDP_LAT; s++) pipe[s][l] <= pipe[s-1][l];
    end
  end

  assign bus.tg_result0 = pipe[FEDP_LAT-1][0];
  assign bus.tg_result1 = pipe[FEDP_LAT-1][1];
  assign bus.tg_result2 = pipe[FEDP_LAT-1][2];
  assign bus.tg_result3 = pipe[FEDP_LAT-1][3];

  // ---------------- monitors ----------------
  typedef struct {
    int                 c;
    logic signed [15:0] p0;
    logic signed [15:0] p3;
  } issue_t;

  int     cyc     = 0;
  int     opr_cnt = 0;
  issue_t iq [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.op_ready) opr_cnt <= opr_cnt + 1;
    if (bus.tg_issue) iq.push_back('{c: cyc, p0: bus.tg_psum0, p3: bus.tg_psum3});
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [KW-1:0] k, output int c0);
    c0          = cyc;
    bus.k_steps = k;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic check_data(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_d0"}, bus.out_data0, e0);
    check({tag, "_d1"}, bus.out_data1, e1);
    check({tag, "_d2"}, bus.out_data2, e2);
    check({tag, "_d3"}, bus.out_data3, e3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int base;
    int ob;
`ifdef BTG_CTRL_PERF_EN
    logic [31:0] pb0, ps0;
`endif

    bus.start     = 1'b0;
    bus.k_steps   = '0;
    bus.op_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_busy",      bus.busy,      0);
    check("rst_op_ready",  bus.op_ready,  0);
    check("rst_tg_issue",  bus.tg_issue,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_psum0",     bus.tg_psum0,  0);
    check("rst_out_data0", bus.out_data0, 0);
`ifdef BTG_CTRL_PERF_EN
    check("rst_perf_busy",  perf_busy_cycles,  0);
    check("rst_perf_stall", perf_stall_cycles, 0);
`endif
    rstn = 1'b1;
    tick();

    // 1) single beat, fixed lane values
    mode = 0;
    bus.op_valid = 1'b1;
    base = iq.size();
    start_job(1, c0);
    check("t1_op_ready", bus.op_ready, 1);
    check("t1_tg_issue", bus.tg_issue, 1);
    check("t1_busy",     bus.busy,     1);
    wait_out(10);
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_latency",   cyc,           c0 + 4);
    check("t1_nbeats",    iq.size() - base, 1);
    if (iq.size() > base) begin
      check("t1_issue_cyc", iq[base].c,  c0 + 1);
      check("t1_psum0",     iq[base].p0, 0);
    end
    check_data("t1", 5, -3, 7, 0);
    finish_out();
    check("t1_idle_busy",  bus.busy,      0);
    check("t1_idle_valid", bus.out_valid, 0);

    // 2) three beats, psum feedback
    mode = 1;
    base = iq.size();
    start_job(3, c0);
    wait_out(20);
    check("t2_out_valid", bus.out_valid, 1);
    check("t2_latency",   cyc,           c0 + 10);
    check("t2_nbeats",    iq.size() - base, 3);
    for (int i = 0; i < 3 && base + i < iq.size(); i++) begin
      check($sformatf("t2_issue_cyc%0d", i), iq[base+i].c,  c0 + 1 + 3 * i);
      check($sformatf("t2_psum0_b%0d", i),   iq[base+i].p0, 10 * i);
      check($sformatf("t2_psum3_b%0d", i),   iq[base+i].p3, 10 * i);
    end
    check_data("t2", 30, 30, 30, 30);
    finish_out();

    // 3) zero-length job
    base = iq.size();
    ob   = opr_cnt;
    start_job(0, c0);
    check("t3_out_valid", bus.out_valid, 1);
    check("t3_latency",   cyc,           c0 + 1);
    check_data("t3", 0, 0, 0, 0);
    tick();
    check("t3_valid_held", bus.out_valid, 1);
    finish_out();
    check("t3_no_op_ready", opr_cnt - ob,     0);
    check("t3_no_issue",    iq.size() - base, 0);

    // 4) upstream stall before beat 2, downstream stall on the result
    mode = 1;
    bus.op_valid = 1'b1;
    base = iq.size();
`ifdef BTG_CTRL_PERF_EN
    pb0 = perf_busy_cycles;
    ps0 = perf_stall_cycles;
`endif
    start_job(2, c0);
    tick();
    bus.op_valid = 1'b0;
    repeat (6) tick();
    bus.op_valid = 1'b1;
    wait_out(10);
    check("t4_out_valid", bus.out_valid, 1);
    check("t4_latency",   cyc,           c0 + 11);
    repeat (3) tick();
    check("t4_valid_held", bus.out_valid, 1);
    check_data("t4", 20, 20, 20, 20);
    finish_out();
    check("t4_nbeats", iq.size() - base, 2);
    if (iq.size() > base + 1) begin
      check("t4_b2_cyc",   iq[base+1].c,  c0 + 8);
      check("t4_b2_psum0", iq[base+1].p0, 10);
    end
`ifdef BTG_CTRL_PERF_EN
    check("t4_perf_stall", perf_stall_cycles - ps0, 7);
    check("t4_perf_busy",  perf_busy_cycles - pb0,  14);
`endif

    // 5) start pulsed mid-job is ignored
    mode = 1;
    base = iq.size();
    start_job(2, c0);
    tick();
    bus.start   = 1'b1;
    bus.k_steps = 5;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_out(20);
    check("t5_out_valid", bus.out_valid, 1);
    check("t5_latency",   cyc,           c0 + 7);
    check("t5_nbeats",    iq.size() - base, 2);
    check_data("t5", 20, 20, 20, 20);
    finish_out();
    repeat (2) tick();
    check("t5_not_queued", bus.busy, 0);

    // 6) reset during WAIT of beat 2, then a clean job
    mode = 1;
    start_job(3, c0);
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    check("t6_busy",      bus.busy,      0);
    check("t6_op_ready",  bus.op_ready,  0);
    check("t6_tg_issue",  bus.tg_issue,  0);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_psum0",     bus.tg_psum0,  0);
    check("t6_out_data0", bus.out_data0, 0);
`ifdef BTG_CTRL_PERF_EN
    check("t6_perf_busy", perf_busy_cycles, 0);
`endif
    tick();
    tick();
    rstn = 1'b1;
    tick();
    mode = 0;
    base = iq.size();
    start_job(1, c0);
    wait_out(10);
    check("t6_out_valid", bus.out_valid, 1);
    check("t6_latency",   cyc,           c0 + 4);
    check("t6_nbeats",    iq.size() - base, 1);
    if (iq.size() > base) check("t6_psum0_first", iq[base].p0, 0);
    check_data("t6", 5, -3, 7, 0);
    finish_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bthreadgroup_ctrl.md
# bthreadgroup_ctrl

Sequencing controller for one bThreadgroup (four bFEDP lanes behind 16-to-4 activation muxes). It accepts a job of `k_steps` operand beats and handshakes each beat from the upstream operand/metadata stream; the weight, select and activation buses themselves route directly to the threadgroup and do not pass through this block. Between beats it holds the four lane results and feeds them back as `partial_sum` for the next beat, so one job yields a K-chunked dot product per lane. After the last beat it presents the four 16-bit results on a valid/ready output port.

## Interface
- `FEDP_LAT`, 2, cycles from a beat being presented to the threadgroup until `result0..3` for that beat are valid (≥1)
- `KW`, 8, width of the beat-count field

- `clk` in 1 — clock
- `rstn` in 1 — asynchronous active-low reset
- `start` in 1 — job start pulse; sampled only in IDLE
- `k_steps` in KW — beats in the job, captured when `start` is accepted
- `busy` out 1 — high in every state except IDLE
- `op_valid` in 1 — upstream operand beat available
- `op_ready` out 1 — controller accepts a beat
- `tg_issue` out 1 — a beat is on the threadgroup inputs this cycle (`op_valid & op_ready`)
- `tg_psum0..3` out 16 signed — drives threadgroup `partial_sum0..3`
- `tg_result0..3` in 16 signed — threadgroup `result0..3`
- `out_valid` out 1 — job results available
- `out_ready` in 1 — downstream accepts the results
- `out_data0..3` out 16 signed — final lane results
- `perf_busy_cycles` out 32 — present only with `BTG_CTRL_PERF_EN`
- `perf_stall_cycles` out 32 — present only with `BTG_CTRL_PERF_EN`

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- **IDLE.** On `start`: capture `k_steps`, clear the beat counter and the four accumulators `acc0..3`, and set `first=1`. Go to ISSUE if `k_steps≠0`, else go to OUT with all results 0.
- **ISSUE.** `op_ready=1`. On the handshake, increment the beat counter, load the wait counter with `FEDP_LAT-1`, clear `first`, and go to WAIT. If `op_valid` is low, stay in ISSUE (this is a stall).
- `tg_psum_i` = 0 while `first=1`; otherwise it equals `acc_i`. `tg_psum_i` is held stable through ISSUE and WAIT.
- **WAIT.** Decrement the wait counter. When it reaches 0, latch `acc_i ← tg_result_i`. Then go to OUT if the beat count equals `k_steps`, else go to ISSUE.
- **OUT.** `out_valid=1` and `out_data_i = acc_i`, both held until `out_ready`. On the handshake, go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor restarts the job.
- Results wrap at 16 bits. The controller adds no arithmetic; accumulation happens inside bFEDP.
- Asynchronous reset at any time, mid-job included, forces IDLE and aborts the job. The upstream beat is not consumed.

## Timing
- Reset values:
  - `busy`, `op_ready`, `tg_issue`, `out_valid` = 0.
  - `tg_psum0..3`, `out_data0..3` = 0.
  - Perf counters = 0.
- `start` accepted at cycle S → `op_ready=1` at S+1.
- A beat handshake at cycle T:
  - `tg_issue=1` at T (combinational from `op_valid`).
  - Result latched at the end of cycle T+FEDP_LAT.
  - Next `op_ready` at T+FEDP_LAT+1.
- Throughput is one beat per FEDP_LAT+1 cycles with no upstream stalls.
- Last beat at T → `out_valid` at T+FEDP_LAT+1.
- `k_steps=0` → `out_valid` the cycle after `start`.
- Back-to-back jobs: `start` is accepted no earlier than the cycle after the output handshake.

## Configuration
- `BTG_CTRL_PERF_EN` defined:
  - `perf_busy_cycles` increments every cycle `busy=1`.
  - `perf_stall_cycles` increments every cycle in ISSUE with `op_valid=0`, and every cycle in OUT with `out_ready=0`.
  - Both counters saturate at 2^32−1 and clear only on reset.
- `BTG_CTRL_PERF_EN` undefined: both ports and their counters are absent. Functional behaviour is identical either way.

## Test plan
- FEDP_LAT=2, `k_steps=1`, `op_valid` held high, threadgroup model returns 5/−3/7/0 → `tg_psum` = 0 on the beat, `out_data` = 5/−3/7/0, `out_valid` 4 cycles after `start`.
- `k_steps=3`, model returns psum+10 → `tg_psum` = 0, 10, 20 on the three beats; `out_data` = 30 on all lanes; `tg_issue` every 3rd cycle.
- `k_steps=0` → `out_valid` at S+1 with all zeros; `op_ready` never asserts.
- `op_valid` low for 4 cycles before beat 2, `out_ready` low for 3 cycles (with `BTG_CTRL_PERF_EN`) → `perf_stall_cycles` = 7; results unchanged.
- `start` pulsed mid-job → ignored; beat count and results match a single job.
- `rstn` low while in WAIT of beat 2 → all outputs return to reset values; a new `start` runs a clean job with `tg_psum` = 0 on its first beat.
